// File: rtl/rec_play_addr_sequencer_if.sv
// Control and memory-port bundle for the record/playback address sequencer.
// master drives the record/play controls; slave is the sequencer side.
interface rec_play_addr_sequencer_if #(
  parameter int ADDR_W = 10
);
  logic              start_record;
  logic              start_play;
  logic              stop;
  logic              loop_en;
  logic              sample_strobe;
  logic [ADDR_W-1:0] address;
  logic              mem_we;
  logic              rd_en;
  logic              recording;
  logic              playing;
  logic [ADDR_W:0]   msg_len;
  logic              rec_full;
  logic              play_done;

  modport master (
    output start_record, start_play, stop, loop_en, sample_strobe,
    input  address, mem_we, rd_en, recording, playing, msg_len, rec_full, play_done
  );

  modport slave (
    input  start_record, start_play, stop, loop_en, sample_strobe,
    output address, mem_we, rd_en, recording, playing, msg_len, rec_full, play_done
  );
endinterface

// File: rtl/rec_play_addr_sequencer.sv
// Record/playback address generator: owns write/read pointers and message length
// and drives the single shared sample-RAM address port.
module rec_play_addr_sequencer #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  rec_play_addr_sequencer_if.slave     bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECORD = 2'd1,
    ST_PLAY   = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   LEN_ZERO  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   LEN_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   FULL_LEN  = (ADDR_W+1)'(DEPTH);

  state_t            state_r, state_nxt_s;
  logic [ADDR_W-1:0] wr_ptr_r, wr_ptr_nxt_s;
  logic [ADDR_W-1:0] rd_ptr_r, rd_ptr_nxt_s;
  logic [ADDR_W:0]   msg_len_r, msg_len_nxt_s;
  logic              rec_full_r, rec_full_nxt_s;
  logic              play_done_r, play_done_nxt_s;
  logic              wr_last_s, rd_last_s, has_msg_s;
  logic [ADDR_W-1:0] address_s;
  logic              mem_we_s, rd_en_s, recording_s, playing_s;

  // The final-sample tests compare against the limit directly so pointers never pass DEPTH-1.
  assign wr_last_s = (wr_ptr_r == LAST_ADDR);
  assign rd_last_s = (({1'b0, rd_ptr_r} + LEN_ONE) == msg_len_r);
  assign has_msg_s = (msg_len_r != LEN_ZERO);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state selection: stop, then full/end detection, then start requests.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start_record) begin
          state_nxt_s = ST_RECORD;
        end else if (bus.start_play && has_msg_s) begin
          state_nxt_s = ST_PLAY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RECORD: begin
        if ((bus.sample_strobe && wr_last_s) || bus.stop) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RECORD;
        end
      end
      ST_PLAY: begin
        if (bus.stop || (bus.sample_strobe && rd_last_s && !bus.loop_en)) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_PLAY;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Pointer, message-length and status-pulse next values.
  always_comb begin
    wr_ptr_nxt_s    = wr_ptr_r;
    rd_ptr_nxt_s    = rd_ptr_r;
    msg_len_nxt_s   = msg_len_r;
    rec_full_nxt_s  = 1'b0;
    play_done_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start_record) begin
          wr_ptr_nxt_s = ADDR_ZERO;
        end else if (bus.start_play && has_msg_s) begin
          rd_ptr_nxt_s = ADDR_ZERO;
        end else begin
          wr_ptr_nxt_s = wr_ptr_r;
        end
      end
      ST_RECORD: begin
        if (bus.sample_strobe && wr_last_s) begin
          msg_len_nxt_s  = FULL_LEN;
          rec_full_nxt_s = 1'b1;
          wr_ptr_nxt_s   = ADDR_ZERO;
        end else if (bus.sample_strobe && bus.stop) begin
          // The coincident write still lands, so it counts toward the length.
          msg_len_nxt_s = {1'b0, wr_ptr_r} + LEN_ONE;
          wr_ptr_nxt_s  = ADDR_ZERO;
        end else if (bus.stop) begin
          msg_len_nxt_s = {1'b0, wr_ptr_r};
          wr_ptr_nxt_s  = ADDR_ZERO;
        end else if (bus.sample_strobe) begin
          wr_ptr_nxt_s = wr_ptr_r + ADDR_ONE;
        end else begin
          wr_ptr_nxt_s = wr_ptr_r;
        end
      end
      ST_PLAY: begin
        if (bus.stop) begin
          rd_ptr_nxt_s = ADDR_ZERO;
        end else if (bus.sample_strobe && rd_last_s) begin
          rd_ptr_nxt_s    = ADDR_ZERO;
          play_done_nxt_s = !bus.loop_en;
        end else if (bus.sample_strobe) begin
          rd_ptr_nxt_s = rd_ptr_r + ADDR_ONE;
        end else begin
          rd_ptr_nxt_s = rd_ptr_r;
        end
      end
      default: begin
        wr_ptr_nxt_s = ADDR_ZERO;
        rd_ptr_nxt_s = ADDR_ZERO;
      end
    endcase
  end

  // Datapath registers; an asynchronous reset discards any message in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r    <= ADDR_ZERO;
      rd_ptr_r    <= ADDR_ZERO;
      msg_len_r   <= LEN_ZERO;
      rec_full_r  <= 1'b0;
      play_done_r <= 1'b0;
    end else begin
      wr_ptr_r    <= wr_ptr_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      msg_len_r   <= msg_len_nxt_s;
      rec_full_r  <= rec_full_nxt_s;
      play_done_r <= play_done_nxt_s;
    end
  end

  // Memory-port decode; strobes pass straight through for zero-latency access.
  always_comb begin
    address_s   = ADDR_ZERO;
    mem_we_s    = 1'b0;
    rd_en_s     = 1'b0;
    recording_s = 1'b0;
    playing_s   = 1'b0;
    case (state_r)
      ST_RECORD: begin
        address_s   = wr_ptr_r;
        mem_we_s    = bus.sample_strobe;
        recording_s = 1'b1;
      end
      ST_PLAY: begin
        address_s = rd_ptr_r;
        rd_en_s   = bus.sample_strobe;
        playing_s = 1'b1;
      end
      ST_IDLE: address_s = ADDR_ZERO;
      default: address_s = ADDR_ZERO;
    endcase
  end

  assign bus.address   = address_s;
  assign bus.mem_we    = mem_we_s;
  assign bus.rd_en     = rd_en_s;
  assign bus.recording = recording_s;
  assign bus.playing   = playing_s;
  assign bus.msg_len   = msg_len_r;
  assign bus.rec_full  = rec_full_r;
  assign bus.play_done = play_done_r;

endmodule

// File: tb/tb_rec_play_addr_sequencer.sv
// Self-checking bench: directed vector table, corner-case sequences and
// randomized traffic compared against a sample-counting reference model.
module tb_rec_play_addr_sequencer;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 8;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  rec_play_addr_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  rec_play_addr_sequencer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 record, 2 play; counts samples rather than pointers.
  int m_mode, m_writes, m_reads, m_len;
  bit m_full, m_done;

  task automatic model_reset();
    m_mode = 0; m_writes = 0; m_reads = 0; m_len = 0; m_full = 0; m_done = 0;
  endtask

  task automatic model_step(input bit sr, input bit sp, input bit st, input bit le, input bit ss);
    m_full = 0;
    m_done = 0;
    if (m_mode == 0) begin
      if (sr) begin m_mode = 1; m_writes = 0; end
      else if (sp && m_len != 0) begin m_mode = 2; m_reads = 0; end
    end else if (m_mode == 1) begin
      if (ss) m_writes++;
      if (m_writes == DEPTH) begin m_len = DEPTH; m_full = 1; m_mode = 0; end
      else if (st) begin m_len = m_writes; m_mode = 0; end
    end else begin
      if (ss) m_reads++;
      if (st) m_mode = 0;
      else if (ss && (m_reads % m_len) == 0 && !le) begin m_done = 1; m_mode = 0; end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
    end
  endtask

  task automatic drive(input bit sr, input bit sp, input bit st, input bit le, input bit ss);
    bus.start_record = sr; bus.start_play = sp; bus.stop = st;
    bus.loop_en = le; bus.sample_strobe = ss;
  endtask

  task automatic model_check(input bit ss);
    int exp_addr;
    exp_addr = (m_mode == 1) ? m_writes : (m_mode == 2) ? (m_reads % m_len) : 0;
    chk("m.address",   32'(bus.address),   32'(exp_addr));
    chk("m.mem_we",    32'(bus.mem_we),    32'(ss && m_mode == 1));
    chk("m.rd_en",     32'(bus.rd_en),     32'(ss && m_mode == 2));
    chk("m.recording", 32'(bus.recording), 32'(m_mode == 1));
    chk("m.playing",   32'(bus.playing),   32'(m_mode == 2));
    chk("m.msg_len",   32'(bus.msg_len),   32'(m_len));
    chk("m.rec_full",  32'(bus.rec_full),  32'(m_full));
    chk("m.play_done", 32'(bus.play_done), 32'(m_done));
  endtask

  // One clock: drive after the edge, check at the falling edge, advance the model.
  task automatic cycle(input bit sr, input bit sp, input bit st, input bit le, input bit ss);
    drive(sr, sp, st, le, ss);
    @(negedge clk);
    model_check(ss);
    @(posedge clk);
    model_step(sr, sp, st, le, ss);
    #1;
  endtask

  typedef struct packed {
    logic sr, sp, st, le, ss;
    logic [3:0] addr;
    logic we, rd, rec, play;
    logic [4:0] len;
    logic full, done;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  initial begin
    // sr sp st le ss | addr we rd rec play len full done
    vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 4'd0,1'b0,1'b0,1'b0,1'b0,5'd0,1'b0,1'b0};
    vecs[1]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, 4'd0,1'b0,1'b0,1'b0,1'b0,5'd0,1'b0,1'b0};
    vecs[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 4'd0,1'b0,1'b0,1'b0,1'b0,5'd0,1'b0,1'b0};
    vecs[3]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, 4'd0,1'b0,1'b0,1'b0,1'b0,5'd0,1'b0,1'b0};
    vecs[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 4'd0,1'b1,1'b0,1'b1,1'b0,5'd0,1'b0,1'b0};
    vecs[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 4'd1,1'b1,1'b0,1'b1,1'b0,5'd0,1'b0,1'b0};
    vecs[6]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, 4'd2,1'b0,1'b0,1'b1,1'b0,5'd0,1'b0,1'b0};
    vecs[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 4'd2,1'b1,1'b0,1'b1,1'b0,5'd0,1'b0,1'b0};
    vecs[8]  = '{1'b0,1'b0,1'b1,1'b0,1'b0, 4'd3,1'b0,1'b0,1'b1,1'b0,5'd0,1'b0,1'b0};
    vecs[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 4'd0,1'b0,1'b0,1'b0,1'b0,5'd3,1'b0,1'b0};
    vecs[10] = '{1'b0,1'b1,1'b0,1'b0,1'b0, 4'd0,1'b0,1'b0,1'b0,1'b0,5'd3,1'b0,1'b0};
    vecs[11] = '{1'b0,1'b0,1'b0,1'b0,1'b1, 4'd0,1'b0,1'b1,1'b0,1'b1,5'd3,1'b0,1'b0};
    vecs[12] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 4'd1,1'b0,1'b0,1'b0,1'b1,5'd3,1'b0,1'b0};
    vecs[13] = '{1'b0,1'b0,1'b0,1'b0,1'b1, 4'd1,1'b0,1'b1,1'b0,1'b1,5'd3,1'b0,1'b0};
    vecs[14] = '{1'b0,1'b0,1'b0,1'b0,1'b1, 4'd2,1'b0,1'b1,1'b0,1'b1,5'd3,1'b0,1'b0};
    vecs[15] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 4'd0,1'b0,1'b0,1'b0,1'b0,5'd3,1'b0,1'b1};
    vecs[16] = '{1'b0,1'b1,1'b0,1'b1,1'b0, 4'd0,1'b0,1'b0,1'b0,1'b0,5'd3,1'b0,1'b0};
    vecs[17] = '{1'b0,1'b0,1'b0,1'b1,1'b1, 4'd0,1'b0,1'b1,1'b0,1'b1,5'd3,1'b0,1'b0};
    vecs[18] = '{1'b0,1'b0,1'b0,1'b1,1'b1, 4'd1,1'b0,1'b1,1'b0,1'b1,5'd3,1'b0,1'b0};
    vecs[19] = '{1'b0,1'b0,1'b0,1'b1,1'b1, 4'd2,1'b0,1'b1,1'b0,1'b1,5'd3,1'b0,1'b0};
    vecs[20] = '{1'b0,1'b0,1'b0,1'b1,1'b1, 4'd0,1'b0,1'b1,1'b0,1'b1,5'd3,1'b0,1'b0};
    vecs[21] = '{1'b0,1'b0,1'b1,1'b0,1'b1, 4'd1,1'b0,1'b1,1'b0,1'b1,5'd3,1'b0,1'b0};
    vecs[22] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 4'd0,1'b0,1'b0,1'b0,1'b0,5'd3,1'b0,1'b0};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    bus.sample_strobe = 1'b1;
    #1;
    chk("rst.address",   32'(bus.address),   32'd0);
    chk("rst.mem_we",    32'(bus.mem_we),    32'd0);
    chk("rst.recording", 32'(bus.recording), 32'd0);
    chk("rst.msg_len",   32'(bus.msg_len),   32'd0);
    bus.sample_strobe = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].sr, vecs[i].sp, vecs[i].st, vecs[i].le, vecs[i].ss);
      @(negedge clk);
      chk($sformatf("vec%0d.address", i),   32'(bus.address),   32'(vecs[i].addr));
      chk($sformatf("vec%0d.mem_we", i),    32'(bus.mem_we),    32'(vecs[i].we));
      chk($sformatf("vec%0d.rd_en", i),     32'(bus.rd_en),     32'(vecs[i].rd));
      chk($sformatf("vec%0d.recording", i), 32'(bus.recording), 32'(vecs[i].rec));
      chk($sformatf("vec%0d.playing", i),   32'(bus.playing),   32'(vecs[i].play));
      chk($sformatf("vec%0d.msg_len", i),   32'(bus.msg_len),   32'(vecs[i].len));
      chk($sformatf("vec%0d.rec_full", i),  32'(bus.rec_full),  32'(vecs[i].full));
      chk($sformatf("vec%0d.play_done", i), 32'(bus.play_done), 32'(vecs[i].done));
      @(posedge clk);
      model_step(vecs[i].sr, vecs[i].sp, vecs[i].st, vecs[i].le, vecs[i].ss);
      #1;
    end

    // Record 7 then stop; then 7 with stop on the 7th strobe.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("stop.msg_len", 32'(bus.msg_len), 32'd7);
    chk("stop.recording", 32'(bus.recording), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("stop_strobe.msg_len", 32'(bus.msg_len), 32'd7);

    // Fill to DEPTH: auto-stop, one-cycle rec_full, later strobes do not write.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("full.rec_full", 32'(bus.rec_full), 32'd1);
    chk("full.msg_len", 32'(bus.msg_len), 32'd8);
    chk("full.recording", 32'(bus.recording), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("full.no_we", 32'(bus.mem_we), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("full.pulse_end", 32'(bus.rec_full), 32'd0);

    // Asynchronous reset in the middle of a recording.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.address",   32'(bus.address),   32'd0);
    chk("arst.mem_we",    32'(bus.mem_we),    32'd0);
    chk("arst.recording", 32'(bus.recording), 32'd0);
    chk("arst.msg_len",   32'(bus.msg_len),   32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("arst.no_play", 32'(bus.playing), 32'd0);

    // Randomized traffic against the model.
    begin
      bit le;
      le = 1'b0;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(0, 15) == 0) le = ~le;
        cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 24) == 0), le, ($urandom_range(0, 1) == 1));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
